// File: rtl/peak_detect_pkg.sv
// Shared types and default geometry for the multi-bin range peak detector.
package peak_detect_pkg;

    localparam int DEF_PT_W   = 10;
    localparam int DEF_BIN_W  = 4;
    localparam int DEF_POINTS = 2 ** DEF_PT_W;
    localparam int DEF_ADDR_W = DEF_BIN_W + DEF_PT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Default-geometry tag layout; the top re-declares it at its own widths.
    typedef struct packed {
        logic                  valid;
        logic [DEF_BIN_W-1:0]  bin;
        logic [DEF_PT_W-1:0]   index;
        logic                  in_win;
        logic                  last;
    } tag_t;

endpackage

// File: rtl/peak_detect_multi_rd_tag_pipe.sv
// Fixed-depth shift register that carries read tags alongside RAM read latency.
module rd_tag_pipe
    import peak_detect_pkg::*;
#(
    parameter type T     = tag_t,
    parameter int  DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  T     tag_i,
    output T     tag_o
);

    T stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/peak_detect_multi.sv
// Scans NUM_BINS range bins, reporting the windowed peak plus both neighbours per bin.
module peak_detect_multi
    import peak_detect_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PT_W     = DEF_PT_W,
    parameter int NUM_BINS = 9,
    parameter int BIN_W    = DEF_BIN_W,
    parameter int RD_LAT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PT_W-1:0]       win_lo,
    input  logic [PT_W-1:0]       win_hi,
    output logic                  rd_en,
    output logic [BIN_W+PT_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output logic                  pk_valid,
    output logic [BIN_W-1:0]      pk_bin,
    output logic [DATA_W-1:0]     pk_value,
    output logic [PT_W-1:0]       pk_index,
    output logic [DATA_W-1:0]     pk_left,
    output logic [DATA_W-1:0]     pk_right,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam logic [PT_W-1:0]  IDX_MAX  = {PT_W{1'b1}};
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NUM_BINS - 1);

    typedef struct packed {
        logic             valid;
        logic [BIN_W-1:0] bin;
        logic [PT_W-1:0]  index;
        logic             in_win;
        logic             last;
    } pd_tag_t;

    state_t            state_q, state_d;
    logic [PT_W-1:0]   win_lo_q, win_lo_d, win_hi_q, win_hi_d;
    logic [PT_W-1:0]   r_lo_q, r_lo_d, r_hi_q, r_hi_d;
    logic [PT_W-1:0]   idx_q, idx_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic              cfg_err_q;
    logic              start_ok, start_bad;
    logic [PT_W-1:0]   r_lo_in, r_hi_in;

    logic              pk_valid_q;
    logic [BIN_W-1:0]  pk_bin_q;
    logic [DATA_W-1:0] pk_value_q, pk_left_q, pk_right_q;
    logic [PT_W-1:0]   pk_index_q;

    assign start_ok  = (state_q == IDLE) && start && (win_lo <= win_hi);
    assign start_bad = (state_q == IDLE) && start && (win_lo > win_hi);
    // Clamp before the +/-1 so the read range never wraps around the bin.
    assign r_lo_in   = (win_lo == '0) ? '0 : win_lo - PT_W'(1);
    assign r_hi_in   = (win_hi == IDX_MAX) ? IDX_MAX : win_hi + PT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            win_lo_q  <= '0;
            win_hi_q  <= '0;
            r_lo_q    <= '0;
            r_hi_q    <= '0;
            idx_q     <= '0;
            bin_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_lo_q  <= win_lo_d;
            win_hi_q  <= win_hi_d;
            r_lo_q    <= r_lo_d;
            r_hi_q    <= r_hi_d;
            idx_q     <= idx_d;
            bin_q     <= bin_d;
            cfg_err_q <= start_bad;
        end
    end

    always_comb begin
        state_d  = state_q;
        win_lo_d = win_lo_q;
        win_hi_d = win_hi_q;
        r_lo_d   = r_lo_q;
        r_hi_d   = r_hi_q;
        idx_d    = idx_q;
        bin_d    = bin_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d  = SCAN;
                    win_lo_d = win_lo;
                    win_hi_d = win_hi;
                    r_lo_d   = r_lo_in;
                    r_hi_d   = r_hi_in;
                    idx_d    = r_lo_in;
                    bin_d    = '0;
                end
            end
            SCAN: begin
                if (idx_q == r_hi_q) begin
                    idx_d = r_lo_q;
                    if (bin_q == BIN_LAST) state_d = DRAIN;
                    else                   bin_d   = bin_q + BIN_W'(1);
                end else begin
                    idx_d = idx_q + PT_W'(1);
                end
            end
            DRAIN: begin
                if (pk_valid_q && (pk_bin_q == BIN_LAST)) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_en   = (state_q == SCAN);
    assign rd_addr = {bin_q, idx_q};
    assign busy    = (state_q == SCAN) || (state_q == DRAIN);
    assign done    = (state_q == FIN);
    assign cfg_err = cfg_err_q;

    pd_tag_t tag_in, tag_al;

    always_comb begin
        tag_in        = '0;
        tag_in.valid  = rd_en;
        tag_in.bin    = bin_q;
        tag_in.index  = idx_q;
        tag_in.in_win = (idx_q >= win_lo_q) && (idx_q <= win_hi_q);
        tag_in.last   = (idx_q == r_hi_q);
    end

    rd_tag_pipe #(
        .T     (pd_tag_t),
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_al)
    );

    logic [DATA_W-1:0] max_q, max_d, left_q, left_d, right_q, right_d, prev_q;
    logic [PT_W-1:0]   pidx_q, pidx_d;
    logic              rpend_q, rpend_d;
    logic              upd, emit;

    // The win_lo sample seeds the max so an all-zero bin still reports win_lo.
    assign upd  = tag_al.valid &&
                  ((tag_al.index == win_lo_q) || (tag_al.in_win && (rd_data > max_q)));
    assign emit = tag_al.valid && tag_al.last;

    always_comb begin
        max_d   = max_q;
        pidx_d  = pidx_q;
        left_d  = left_q;
        right_d = right_q;
        rpend_d = rpend_q;
        if (upd) begin
            max_d   = rd_data;
            pidx_d  = tag_al.index;
            left_d  = (tag_al.index == '0) ? '0 : prev_q;
            right_d = '0;
            rpend_d = (tag_al.index != IDX_MAX);
        end else if (tag_al.valid && rpend_q) begin
            right_d = rd_data;
            rpend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q      <= '0;
            pidx_q     <= '0;
            left_q     <= '0;
            right_q    <= '0;
            rpend_q    <= 1'b0;
            prev_q     <= '0;
            pk_valid_q <= 1'b0;
            pk_bin_q   <= '0;
            pk_value_q <= '0;
            pk_index_q <= '0;
            pk_left_q  <= '0;
            pk_right_q <= '0;
        end else begin
            pk_valid_q <= emit;
            if (tag_al.valid) prev_q <= rd_data;
            if (emit) begin
                pk_bin_q   <= tag_al.bin;
                pk_value_q <= max_d;
                pk_index_q <= pidx_d;
                pk_left_q  <= left_d;
                pk_right_q <= right_d;
                max_q      <= '0;
                pidx_q     <= '0;
                left_q     <= '0;
                right_q    <= '0;
                rpend_q    <= 1'b0;
            end else begin
                max_q      <= max_d;
                pidx_q     <= pidx_d;
                left_q     <= left_d;
                right_q    <= right_d;
                rpend_q    <= rpend_d;
            end
        end
    end

    assign pk_valid = pk_valid_q;
    assign pk_bin   = pk_bin_q;
    assign pk_value = pk_value_q;
    assign pk_index = pk_index_q;
    assign pk_left  = pk_left_q;
    assign pk_right = pk_right_q;

endmodule

// File: tb/tb_peak_detect_multi.sv
// Directed bench for peak_detect_multi: two-bin scans against hand-computed results.
module tb_peak_detect_multi;

    localparam int DATA_W   = 32;
    localparam int PT_W     = 10;
    localparam int NUM_BINS = 2;
    localparam int BIN_W    = 4;
    localparam int RD_LAT   = 3;
    localparam int AW       = BIN_W + PT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [PT_W-1:0]   win_lo, win_hi;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              pk_valid;
    logic [BIN_W-1:0]  pk_bin;
    logic [DATA_W-1:0] pk_value, pk_left, pk_right;
    logic [PT_W-1:0]   pk_index;
    logic              busy, done, cfg_err;

    always #5 clk = ~clk;

    peak_detect_multi #(
        .DATA_W(DATA_W), .PT_W(PT_W), .NUM_BINS(NUM_BINS), .BIN_W(BIN_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .win_lo(win_lo), .win_hi(win_hi),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pk_valid(pk_valid), .pk_bin(pk_bin), .pk_value(pk_value), .pk_index(pk_index),
        .pk_left(pk_left), .pk_right(pk_right), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    // Spectrum RAM model with RD_LAT cycles of read latency.
    logic [DATA_W-1:0] mem [0:2**AW-1];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        rd_pipe[0] <= rd_en ? mem[rd_addr] : 32'hDEAD_BEEF;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign rd_data = rd_pipe[RD_LAT-1];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int r_val [NUM_BINS];
    int r_idx [NUM_BINS];
    int r_left[NUM_BINS];
    int r_right[NUM_BINS];
    int r_cyc [NUM_BINS];
    int n_pk, done_cyc, first_rd, n_rd, min_idx, max_idx, cfg_cnt, busy_cnt;

    task automatic mem_fill(input int b, input int v);
        for (int i = 0; i < 2**PT_W; i++) mem[b*(2**PT_W) + i] = DATA_W'(v);
    endtask

    task automatic mem_set(input int b, input int i, input int v);
        mem[b*(2**PT_W) + i] = DATA_W'(v);
    endtask

    // Pulses start, then watches cycle by cycle (cycle 1 = first after the start edge).
    task automatic run(input int lo, input int hi, input int budget, input bit poke);
        for (int b = 0; b < NUM_BINS; b++) begin
            r_val[b] = -1; r_idx[b] = -1; r_left[b] = -1; r_right[b] = -1; r_cyc[b] = -1;
        end
        n_pk = 0; done_cyc = -1; first_rd = -1; n_rd = 0;
        min_idx = 99999; max_idx = -1; cfg_cnt = 0; busy_cnt = 0;
        @(negedge clk);
        win_lo = PT_W'(lo);
        win_hi = PT_W'(hi);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) @(negedge clk);
            if (rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = c;
                if (int'(rd_addr[PT_W-1:0]) < min_idx) min_idx = int'(rd_addr[PT_W-1:0]);
                if (int'(rd_addr[PT_W-1:0]) > max_idx) max_idx = int'(rd_addr[PT_W-1:0]);
            end
            if (busy)    busy_cnt++;
            if (cfg_err) cfg_cnt++;
            if (pk_valid) begin
                n_pk++;
                if (int'(pk_bin) < NUM_BINS) begin
                    r_val[pk_bin]   = int'(pk_value);
                    r_idx[pk_bin]   = int'(pk_index);
                    r_left[pk_bin]  = int'(pk_left);
                    r_right[pk_bin] = int'(pk_right);
                    r_cyc[pk_bin]   = c;
                end
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            start = poke && (c == 50);
            if (poke && c == 50) begin
                win_lo = PT_W'(600);
                win_hi = PT_W'(500);
            end
        end
        start = 1'b0;
    endtask

    task automatic check_bin(input string t, input int b, input int v, input int i,
                             input int l, input int r, input int cyc);
        check_vec({t, ".value"}, r_val[b], v);
        check_vec({t, ".index"}, r_idx[b], i);
        check_vec({t, ".left"},  r_left[b], l);
        check_vec({t, ".right"}, r_right[b], r);
        check_vec({t, ".cycle"}, r_cyc[b], cyc);
    endtask

    task automatic check_run(input string t, input int nrd, input int lo_i, input int hi_i,
                             input int dcyc);
        check_vec({t, ".first_rd"}, first_rd, 1);
        check_vec({t, ".n_rd"},     n_rd, nrd);
        check_vec({t, ".min_idx"},  min_idx, lo_i);
        check_vec({t, ".max_idx"},  max_idx, hi_i);
        check_vec({t, ".n_pk"},     n_pk, NUM_BINS);
        check_vec({t, ".cfg_err"},  cfg_cnt, 0);
        check_vec({t, ".done_cyc"}, done_cyc, dcyc);
    endtask

    task automatic load_a();
        mem_fill(0, 0);
        for (int i = 0; i < 2**PT_W; i++) mem_set(0, i, i >> 2);
        mem_set(0, 149, 40); mem_set(0, 150, 5000); mem_set(0, 151, 60);
        mem_fill(1, 1);
        mem_set(1, 99, 99999); mem_set(1, 199, 3); mem_set(1, 200, 777); mem_set(1, 201, 12345);
    endtask

    int q_pk, q_done, q_rd, q_busy;

    initial begin
        rst = 1'b1; start = 1'b0; win_lo = '0; win_hi = '0;
        repeat (3) @(negedge clk);
        check_vec("rst.rd_en",    rd_en, 0);
        check_vec("rst.busy",     busy, 0);
        check_vec("rst.done",     done, 0);
        check_vec("rst.pk_valid", pk_valid, 0);
        check_vec("rst.cfg_err",  cfg_err, 0);
        check_vec("rst.pk_value", pk_value, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A: ramp window 100..200, stray start mid-run must be ignored.
        load_a();
        run(100, 200, 240, 1'b1);
        check_run("A", 206, 99, 201, 2*103 + RD_LAT + 2);
        check_bin("A.b0", 0, 5000, 150, 40, 60, 103 + RD_LAT + 1);
        check_bin("A.b1", 1, 777, 200, 3, 12345, 206 + RD_LAT + 1);

        // B: full-width window, peaks at both bin edges.
        mem_fill(0, 1); mem_set(0, 0, 7); mem_set(0, 1, 5);
        mem_fill(1, 2); mem_set(1, 1022, 4); mem_set(1, 1023, 8);
        run(0, 1023, 2100, 1'b0);
        check_run("B", 2048, 0, 1023, 2048 + RD_LAT + 2);
        check_bin("B.b0", 0, 7, 0, 0, 5, 1024 + RD_LAT + 1);
        check_bin("B.b1", 1, 8, 1023, 4, 0, 2048 + RD_LAT + 1);

        // C: ties keep earliest index; out-of-window neighbours feed left/right only.
        mem_fill(0, 0); mem_set(0, 299, 3); mem_set(0, 300, 9); mem_set(0, 301, 4); mem_set(0, 310, 9);
        mem_fill(1, 0); mem_set(1, 255, 70); mem_set(1, 511, 6); mem_set(1, 512, 50);
        run(256, 511, 600, 1'b0);
        check_run("C", 2*258, 255, 512, 2*258 + RD_LAT + 2);
        check_bin("C.b0", 0, 9, 300, 3, 4, 258 + RD_LAT + 1);
        check_bin("C.b1", 1, 6, 511, 0, 50, 516 + RD_LAT + 1);

        // D: all-zero window reports win_lo; outside samples never win.
        mem_fill(0, 0); mem_set(0, 511, 99);
        mem_fill(1, 0); mem_set(1, 1023, 5);
        run(512, 1022, 1100, 1'b0);
        check_run("D", 2*513, 511, 1023, 2*513 + RD_LAT + 2);
        check_bin("D.b0", 0, 0, 512, 99, 0, 513 + RD_LAT + 1);
        check_bin("D.b1", 1, 0, 512, 0, 0, 1026 + RD_LAT + 1);

        // E: inverted window is rejected.
        run(600, 500, 20, 1'b0);
        check_vec("E.cfg_err",  cfg_cnt, 1);
        check_vec("E.n_rd",     n_rd, 0);
        check_vec("E.busy",     busy_cnt, 0);
        check_vec("E.done_cyc", done_cyc, -1);
        check_vec("E.n_pk",     n_pk, 0);

        // F: reset in the middle of bin 1, then a clean rerun.
        load_a();
        run(100, 200, 123, 1'b0);
        check_vec("F.pre_rd_en", rd_en, 1);
        check_vec("F.pre_b0",    r_val[0], 5000);
        rst = 1'b1;
        #1;
        check_vec("F.rd_en",    rd_en, 0);
        check_vec("F.busy",     busy, 0);
        check_vec("F.pk_valid", pk_valid, 0);
        check_vec("F.pk_value", pk_value, 0);
        check_vec("F.pk_index", pk_index, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q_pk = 0; q_done = 0; q_rd = 0; q_busy = 0;
        repeat (300) begin
            @(negedge clk);
            if (pk_valid) q_pk++;
            if (done)     q_done++;
            if (rd_en)    q_rd++;
            if (busy)     q_busy++;
        end
        check_vec("F.quiet_pk",   q_pk, 0);
        check_vec("F.quiet_done", q_done, 0);
        check_vec("F.quiet_rd",   q_rd, 0);
        check_vec("F.quiet_busy", q_busy, 0);
        run(100, 200, 240, 1'b0);
        check_run("F2", 206, 99, 201, 2*103 + RD_LAT + 2);
        check_bin("F2.b0", 0, 5000, 150, 40, 60, 103 + RD_LAT + 1);
        check_bin("F2.b1", 1, 777, 200, 3, 12345, 206 + RD_LAT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
